// File: rtl/frame_fetch_scheduler.sv
// Frame fetch scheduler: issues one read request per video row and tags each row with a
// destination IP, picked round-robin among IPs that still have outstanding-row credit.
module frame_fetch_scheduler #(
    parameter int IP_AMT    = 4,
    parameter int IP_ADDR_W = ($clog2(IP_AMT) > 1) ? $clog2(IP_AMT) : 1,
    parameter int ADDR_W    = 32,
    parameter int ROW_W     = 12,
    parameter int ROW_BEATS = 20,
    parameter int MAX_OUT   = 2,
    parameter int OUT_W     = $clog2(MAX_OUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [ADDR_W-1:0]    frame_base_i,
    input  logic [ADDR_W-1:0]    row_stride_i,
    input  logic [ROW_W-1:0]     row_num_i,
    output logic [ADDR_W-1:0]    req_addr_o,
    output logic [7:0]           req_len_o,
    output logic [IP_ADDR_W-1:0] req_dest_o,
    output logic                 req_valid_o,
    input  logic                 req_ready_i,
    input  logic                 mon_tvalid_i,
    input  logic                 mon_tready_i,
    input  logic                 mon_tlast_i,
    input  logic [IP_ADDR_W-1:0] mon_tdest_i,
    output logic                 busy_o,
    output logic                 frame_done_o,
    output logic                 err_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t               state;
    logic [ADDR_W-1:0]    cur_addr;
    logic [ADDR_W-1:0]    stride_r;
    logic [ROW_W-1:0]     row_num_r;
    logic [ROW_W-1:0]     row_idx;
    logic [IP_ADDR_W-1:0] rr_ptr;
    logic [OUT_W-1:0]     out_cnt [IP_AMT];
    logic [OUT_W-1:0]     cnt_nxt [IP_AMT];
    logic [IP_AMT-1:0]    inc_vec;
    logic [IP_AMT-1:0]    dec_vec;
    logic [IP_AMT-1:0]    elig;
    logic [IP_AMT-1:0]    elig_nxt;
    logic                 hs;
    logic                 cpl;
    logic                 err_set;
    logic                 all_zero;
    logic                 last_row;
    logic [IP_ADDR_W:0]   grant_now;
    logic [IP_ADDR_W:0]   grant_post;

    // Returns {found, index} of the first eligible IP after ptr, wrapping modulo IP_AMT.
    function automatic logic [IP_ADDR_W:0] rr_pick(input logic [IP_ADDR_W-1:0] ptr,
                                                   input logic [IP_AMT-1:0]    el);
        logic                 found;
        logic [IP_ADDR_W-1:0] idx;
        logic [IP_ADDR_W-1:0] cand;
        int                   j;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= IP_AMT; k++) begin
            j    = (int'(ptr) + k) % IP_AMT;
            cand = IP_ADDR_W'(j);
            if (!found && el[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    assign req_len_o = 8'(ROW_BEATS - 1);
    assign last_row  = (row_idx == row_num_r - 1'b1);

    always_comb begin
        hs       = req_valid_o && req_ready_i;
        cpl      = mon_tvalid_i && mon_tready_i && mon_tlast_i;
        err_set  = 1'b0;
        all_zero = 1'b1;
        for (int i = 0; i < IP_AMT; i++) begin
            inc_vec[i] = hs && (req_dest_o == IP_ADDR_W'(i));
            dec_vec[i] = cpl && (mon_tdest_i == IP_ADDR_W'(i));
            cnt_nxt[i] = out_cnt[i];
            if (inc_vec[i] && !dec_vec[i]) begin
                cnt_nxt[i] = out_cnt[i] + 1'b1;
            end else if (dec_vec[i] && !inc_vec[i]) begin
                // A retire with nothing outstanding is a protocol error; the count saturates at 0.
                if (out_cnt[i] == '0) err_set = 1'b1;
                else                  cnt_nxt[i] = out_cnt[i] - 1'b1;
            end
            elig[i]     = out_cnt[i] < OUT_W'(MAX_OUT);
            elig_nxt[i] = cnt_nxt[i] < OUT_W'(MAX_OUT);
            if (out_cnt[i] != '0) all_zero = 1'b0;
        end
        grant_now  = rr_pick(rr_ptr, elig);
        grant_post = rr_pick(req_dest_o, elig_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cur_addr     <= '0;
            stride_r     <= '0;
            row_num_r    <= '0;
            row_idx      <= '0;
            rr_ptr       <= IP_ADDR_W'(IP_AMT - 1);
            req_addr_o   <= '0;
            req_dest_o   <= '0;
            req_valid_o  <= 1'b0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
            err_o        <= 1'b0;
            for (int i = 0; i < IP_AMT; i++) out_cnt[i] <= '0;
        end else begin
            frame_done_o <= 1'b0;
            for (int i = 0; i < IP_AMT; i++) out_cnt[i] <= cnt_nxt[i];
            if (err_set) err_o <= 1'b1;

            case (state)
                IDLE: begin
                    if (start_i) begin
                        stride_r  <= row_stride_i;
                        row_num_r <= row_num_i;
                        row_idx   <= '0;
                        cur_addr  <= frame_base_i;
                        busy_o    <= 1'b1;
                        if (row_num_i == '0) begin
                            state <= DRAIN;
                        end else begin
                            state       <= ISSUE;
                            req_valid_o <= grant_now[IP_ADDR_W];
                            req_addr_o  <= frame_base_i;
                            req_dest_o  <= grant_now[IP_ADDR_W-1:0];
                        end
                    end
                end

                ISSUE: begin
                    if (!req_valid_o) begin
                        if (grant_now[IP_ADDR_W]) begin
                            req_valid_o <= 1'b1;
                            req_addr_o  <= cur_addr;
                            req_dest_o  <= grant_now[IP_ADDR_W-1:0];
                        end
                    end else if (req_ready_i) begin
                        cur_addr <= cur_addr + stride_r;
                        row_idx  <= row_idx + 1'b1;
                        rr_ptr   <= req_dest_o;
                        if (last_row) begin
                            req_valid_o <= 1'b0;
                            state       <= DRAIN;
                        end else if (grant_post[IP_ADDR_W]) begin
                            // Back-to-back issue keeps the request bus at one row per cycle.
                            req_addr_o <= cur_addr + stride_r;
                            req_dest_o <= grant_post[IP_ADDR_W-1:0];
                        end else begin
                            req_valid_o <= 1'b0;
                        end
                    end
                end

                DRAIN: begin
                    if (all_zero) begin
                        frame_done_o <= 1'b1;
                        busy_o       <= 1'b0;
                        state        <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_fetch_scheduler.sv
// Bench for frame_fetch_scheduler: scoreboard of expected row requests plus a per-cycle
// reference model of credits, round-robin choice and frame progress.
module tb_frame_fetch_scheduler;

    localparam int IP_AMT    = 4;
    localparam int IP_ADDR_W = 2;
    localparam int ADDR_W    = 32;
    localparam int ROW_W     = 12;
    localparam int ROW_BEATS = 20;
    localparam int MAX_OUT   = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start_i;
    logic [ADDR_W-1:0]    frame_base_i;
    logic [ADDR_W-1:0]    row_stride_i;
    logic [ROW_W-1:0]     row_num_i;
    logic [ADDR_W-1:0]    req_addr_o;
    logic [7:0]           req_len_o;
    logic [IP_ADDR_W-1:0] req_dest_o;
    logic                 req_valid_o;
    logic                 req_ready_i;
    logic                 mon_tvalid_i;
    logic                 mon_tready_i;
    logic                 mon_tlast_i;
    logic [IP_ADDR_W-1:0] mon_tdest_i;
    logic                 busy_o;
    logic                 frame_done_o;
    logic                 err_o;

    always #5 clk = ~clk;

    frame_fetch_scheduler #(
        .IP_AMT(IP_AMT), .ADDR_W(ADDR_W), .ROW_W(ROW_W),
        .ROW_BEATS(ROW_BEATS), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .frame_base_i(frame_base_i), .row_stride_i(row_stride_i), .row_num_i(row_num_i),
        .req_addr_o(req_addr_o), .req_len_o(req_len_o), .req_dest_o(req_dest_o),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .mon_tvalid_i(mon_tvalid_i), .mon_tready_i(mon_tready_i),
        .mon_tlast_i(mon_tlast_i), .mon_tdest_i(mon_tdest_i),
        .busy_o(busy_o), .frame_done_o(frame_done_o), .err_o(err_o)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                dest;
        bit                chk_dest;
    } row_t;

    row_t sb[$];
    int   exp_dest[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   done_seen = 0;

    // Reference model state
    int                m_state;
    int                m_cnt [IP_AMT];
    int                m_ptr;
    int                m_left;
    int                m_issued;
    logic [ADDR_W-1:0] m_base;
    logic [ADDR_W-1:0] m_stride;
    bit                m_err;
    bit                e_valid, e_busy, e_done;
    logic [ADDR_W-1:0] e_addr;
    int                e_dest;
    bit                armed = 1'b0;

    task automatic chk(input string name, input bit ok, input longint act, input longint exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // Distance from the pointer decides priority: the nearest eligible IP after ptr wins.
    function automatic int rr_pick(input int ptr, input logic [IP_AMT-1:0] el);
        int best = -1;
        int bestd = IP_AMT + 1;
        int d;
        for (int i = 0; i < IP_AMT; i++) begin
            d = (i - ptr - 1 + 2 * IP_AMT) % IP_AMT;
            if (el[i] && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    function automatic logic [ADDR_W-1:0] row_addr(input int k);
        return m_base + ADDR_W'(k) * m_stride;
    endfunction

    always @(negedge clk) begin
        logic [IP_AMT-1:0] el_old, el_new;
        int                nc [IP_AMT];
        bit                hs, cpl, inc, dec, zero;
        int                g;
        row_t              r;

        if (armed) begin
            chk("req_valid", req_valid_o === e_valid, longint'(req_valid_o), longint'(e_valid));
            chk("busy", busy_o === e_busy, longint'(busy_o), longint'(e_busy));
            chk("frame_done", frame_done_o === e_done, longint'(frame_done_o), longint'(e_done));
            chk("err", err_o === m_err, longint'(err_o), longint'(m_err));
            if (e_valid) begin
                chk("req_addr", req_addr_o === e_addr, longint'(req_addr_o), longint'(e_addr));
                chk("req_dest", int'(req_dest_o) == e_dest, longint'(req_dest_o), longint'(e_dest));
                chk("req_len", req_len_o === 8'(ROW_BEATS - 1), longint'(req_len_o), longint'(ROW_BEATS - 1));
            end
        end
        if (frame_done_o === 1'b1) done_seen++;

        if (!rst && req_valid_o === 1'b1 && req_ready_i === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_req", 1'b0, longint'(req_addr_o), 0);
            end else begin
                r = sb.pop_front();
                chk("sb_addr", req_addr_o === r.addr, longint'(req_addr_o), longint'(r.addr));
                if (r.chk_dest)
                    chk("sb_dest", int'(req_dest_o) == r.dest, longint'(req_dest_o), longint'(r.dest));
            end
        end

        hs  = e_valid && (req_ready_i === 1'b1);
        cpl = (mon_tvalid_i === 1'b1) && (mon_tready_i === 1'b1) && (mon_tlast_i === 1'b1);
        if (rst) begin
            m_state = 0; m_ptr = IP_AMT - 1; m_err = 0; m_left = 0; m_issued = 0;
            e_valid = 0; e_busy = 0; e_done = 0; e_addr = '0; e_dest = 0;
            for (int i = 0; i < IP_AMT; i++) m_cnt[i] = 0;
        end else begin
            zero = 1'b1;
            for (int i = 0; i < IP_AMT; i++) begin
                el_old[i] = m_cnt[i] < MAX_OUT;
                if (m_cnt[i] != 0) zero = 1'b0;
                inc = hs && (e_dest == i);
                dec = cpl && (int'(mon_tdest_i) == i);
                nc[i] = m_cnt[i];
                if (inc && !dec) nc[i] = m_cnt[i] + 1;
                if (dec && !inc) begin
                    if (m_cnt[i] == 0) m_err = 1'b1;
                    else nc[i] = m_cnt[i] - 1;
                end
                el_new[i] = nc[i] < MAX_OUT;
            end
            e_done = 1'b0;
            case (m_state)
                0: if (start_i === 1'b1) begin
                    m_base = frame_base_i; m_stride = row_stride_i;
                    m_left = int'(row_num_i); m_issued = 0; e_busy = 1'b1;
                    m_state = (m_left == 0) ? 2 : 1;
                    if (m_left != 0) begin
                        g = rr_pick(m_ptr, el_old);
                        if (g >= 0) begin e_valid = 1; e_addr = frame_base_i; e_dest = g; end
                    end
                end
                1: if (!e_valid) begin
                    g = rr_pick(m_ptr, el_old);
                    if (g >= 0) begin e_valid = 1; e_addr = row_addr(m_issued); e_dest = g; end
                end else if (hs) begin
                    m_ptr = e_dest; m_issued++; m_left--;
                    if (m_left == 0) begin
                        e_valid = 0; m_state = 2;
                    end else begin
                        g = rr_pick(m_ptr, el_new);
                        if (g >= 0) begin e_addr = row_addr(m_issued); e_dest = g; end
                        else e_valid = 0;
                    end
                end
                default: if (zero) begin e_done = 1; e_busy = 0; m_state = 0; end
            endcase
            for (int i = 0; i < IP_AMT; i++) m_cnt[i] = nc[i];
        end
        armed = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_mon();
        mon_tvalid_i = 0; mon_tready_i = 0; mon_tlast_i = 0; mon_tdest_i = '0;
    endtask

    task automatic tlast_at(input int d);
        mon_tvalid_i = 1; mon_tready_i = 1; mon_tlast_i = 1; mon_tdest_i = IP_ADDR_W'(d);
        tick();
        idle_mon();
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] stride,
                            input int rows);
        row_t r;
        for (int k = 0; k < rows; k++) begin
            r.addr = base + ADDR_W'(k) * stride;
            r.chk_dest = exp_dest.size() > 0;
            r.dest = r.chk_dest ? exp_dest.pop_front() : 0;
            sb.push_back(r);
        end
        start_i = 1; frame_base_i = base; row_stride_i = stride; row_num_i = ROW_W'(rows);
        tick();
        start_i = 0;
    endtask

    // One cycle of sink behaviour: maybe retire a row of an IP that has one outstanding,
    // otherwise drive stream activity that is never a completion.
    task automatic retire_step(input int ready_pct);
        int cand[$];
        idle_mon();
        req_ready_i = ($urandom_range(99) < ready_pct);
        for (int i = 0; i < IP_AMT; i++) if (m_cnt[i] > 0) cand.push_back(i);
        if (cand.size() > 0 && $urandom_range(2) == 0) begin
            mon_tvalid_i = 1; mon_tready_i = 1; mon_tlast_i = 1;
            mon_tdest_i = IP_ADDR_W'(cand[$urandom_range(cand.size() - 1)]);
        end else begin
            mon_tvalid_i = ($urandom_range(1) == 1);
            mon_tlast_i  = ($urandom_range(1) == 1);
            mon_tready_i = !(mon_tvalid_i && mon_tlast_i) && ($urandom_range(1) == 1);
            mon_tdest_i  = IP_ADDR_W'($urandom_range(IP_AMT - 1));
        end
        tick();
    endtask

    task automatic wait_done(input string name, input int ready_pct, input int bound);
        int s = done_seen;
        for (int n = 0; n < bound && done_seen == s; n++) retire_step(ready_pct);
        idle_mon();
        req_ready_i = 1;
        chk(name, done_seen != s, longint'(done_seen - s), 1);
    endtask

    initial begin
        rst = 1; start_i = 1; frame_base_i = $urandom; row_stride_i = $urandom;
        row_num_i = ROW_W'($urandom); req_ready_i = 1; mon_tvalid_i = 1; mon_tready_i = 1;
        mon_tlast_i = 1; mon_tdest_i = 2'd3;
        tick();
        start_i = 0; mon_tdest_i = 2'd1;
        tick();
        rst = 0; idle_mon(); req_ready_i = 1;
        repeat (3) tick();

        // Basic fetch with a same-IP retire in the cycle of the first handshake
        exp_dest = {0, 1, 2, 3};
        do_start(32'h1000, 32'h100, 4);
        tlast_at(0);
        repeat (4) tick();
        start_i = 1; frame_base_i = 32'hdead0000; row_num_i = 12'd5;
        tick();
        start_i = 0;
        tick();
        for (int d = 1; d < IP_AMT; d++) begin tlast_at(d); tick(); end
        wait_done("done_basic", 100, 20);

        // Credit stall: 8 rows fill every credit, one retire on IP 2 releases the ninth
        exp_dest = {0, 1, 2, 3, 0, 1, 2, 3, 2};
        do_start($urandom & 32'hffff_ff00, 32'h400, 10);
        repeat (12) tick();
        tlast_at(2);
        repeat (3) tick();
        wait_done("done_credit", 100, 500);

        // Backpressure mid-frame
        do_start($urandom, $urandom, 6);
        repeat (2) tick();
        req_ready_i = 0;
        repeat (5) tick();
        req_ready_i = 1;
        wait_done("done_backpressure", 100, 500);

        // Empty frame
        do_start($urandom, $urandom, 0);
        wait_done("done_empty", 100, 5);

        // Retire with nothing outstanding
        tlast_at(3);
        repeat (3) tick();

        // Reset mid-frame abandons everything
        do_start($urandom, $urandom, 8);
        repeat (3) tick();
        rst = 1; req_ready_i = 0;
        tick();
        rst = 0; req_ready_i = 1;
        sb.delete();
        repeat (4) tick();

        for (int f = 0; f < 8; f++) begin
            repeat ($urandom_range(3)) tick();
            do_start($urandom, $urandom, $urandom_range(1, 12));
            wait_done("done_random", 70, 3000);
        end

        repeat (4) tick();
        chk("sb_leftover", sb.size() == 0, longint'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/frame_fetch_scheduler.md
Name: frame_fetch_scheduler

Overview:
- Sequences the fetch of one video frame as per-row read requests to the AXI read/DMA master.
- Tags each row with a destination image processor (IP), which becomes the tdest of the returning pixel-group stream.
- Shares the IPs round-robin, limited by a per-IP outstanding-row credit.
- Sits upstream of the AXI-Stream router that feeds pixel groups to the IPs, and monitors that stream's tlast handshakes to retire rows.

Parameters:
- IP_AMT, 4, number of image processors.
- IP_ADDR_W, ($clog2(IP_AMT) > 1) ? $clog2(IP_AMT) : 1, width of the destination index.
- ADDR_W, 32, byte address width.
- ROW_W, 12, width of the row count.
- ROW_BEATS, 20, AXI beats per row; driven constant on req_len_o as ROW_BEATS-1.
- MAX_OUT, 2, maximum outstanding rows per IP (≥1).
- OUT_W, $clog2(MAX_OUT+1), width of the per-IP outstanding counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start_i  in  1  one-cycle frame start pulse; sampled only in IDLE.
- frame_base_i  in  ADDR_W  frame base address; sampled with start_i.
- row_stride_i  in  ADDR_W  byte stride between rows; sampled with start_i.
- row_num_i  in  ROW_W  rows in the frame; sampled with start_i.
- req_addr_o  out  ADDR_W  row start address.
- req_len_o  out  8  burst length minus 1 (ROW_BEATS-1).
- req_dest_o  out  IP_ADDR_W  destination IP of the row.
- req_valid_o  out  1  request valid.
- req_ready_i  in  1  request accepted.
- mon_tvalid_i  in  1  monitored pixel stream tvalid.
- mon_tready_i  in  1  monitored pixel stream tready.
- mon_tlast_i  in  1  monitored pixel stream tlast.
- mon_tdest_i  in  IP_ADDR_W  monitored pixel stream tdest.
- busy_o  out  1  frame in progress.
- frame_done_o  out  1  one-cycle frame completion pulse.
- err_o  out  1  sticky error: tlast seen for an IP with zero outstanding rows.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; all outputs 0.
  - Outstanding counters 0, row index 0, round-robin pointer = IP_AMT-1 (so the first grant goes to IP 0).
  - Reset mid-frame abandons the frame immediately, with no frame_done_o.
- Completion event: mon_tvalid_i & mon_tready_i & mon_tlast_i. Retires one row of IP mon_tdest_i.
- Request handshake: req_valid_o & req_ready_i. Adds one row to IP req_dest_o.
- Per-IP outstanding counter:
  - handshake only: +1; completion only: -1.
  - Both on the same IP in the same cycle: unchanged.
  - Completion when the counter is 0: counter stays 0, err_o set until reset.
  - Completion events are tracked in every state, including IDLE.
- Eligible IP: outstanding < MAX_OUT, evaluated on registered counter values.
- Grant: first eligible IP scanning from pointer+1 upward with wrap modulo IP_AMT. The pointer updates to the granted IP on handshake.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE:
    - start_i=1 latches base, stride and row_num; row index=0; next address=base; busy_o=1 from the next cycle.
    - Next state is ISSUE, or DRAIN if row_num=0.
  - ISSUE:
    - When no request is pending and an eligible IP exists, register req_valid_o=1 with req_addr_o=current address and req_dest_o=grant.
    - While req_valid_o=1 and req_ready_i=0, req_addr_o, req_dest_o and req_len_o are held stable. No re-arbitration.
    - On handshake: address += stride (modulo 2^ADDR_W); row index +1.
    - If another row remains and an IP is eligible using post-update counters, req_valid_o stays 1 next cycle, so throughput is 1 row/cycle. Otherwise it drops to 0.
    - Handshake on the last row (index = row_num-1): goto DRAIN.
    - No eligible IP: req_valid_o=0, wait.
  - DRAIN:
    - When all counters are 0: frame_done_o=1 for one cycle, busy_o=0, goto IDLE, on the same edge.
    - row_num=0: frame_done_o pulses on the second cycle after start_i.
- start_i outside IDLE is ignored.
- Latency: start_i in cycle t gives req_valid_o=1 in cycle t+1.

Test Plan:
- Reset: hold rst 2 cycles, any inputs -> req_valid_o, busy_o, frame_done_o, err_o all 0; after release, idle with no requests.
- Basic fetch (IP_AMT=4, MAX_OUT=2, req_ready_i=1):
  - Stimulus: start with base=0x1000, stride=0x100, rows=4.
  - Response: requests on cycles t+1..t+4 with addr 0x1000/0x1100/0x1200/0x1300, dest 0/1/2/3, req_len_o=19; then DRAIN, busy_o=1.
- Credit stall:
  - Stimulus: rows=10, no tlast.
  - Response: exactly 8 requests (dests 0,1,2,3,0,1,2,3), then req_valid_o=0.
  - Then one tlast with tdest=2 -> next request has dest 2 and addr base+8*stride within 2 cycles.
- Backpressure: req_ready_i=0 for 5 cycles mid-frame -> req_valid_o, req_addr_o, req_dest_o unchanged for all 5 cycles; handshake on ready, next row follows.
- Completion:
  - Basic fetch followed by 4 tlasts (one per dest), including one in the same cycle as a request handshake to the same IP -> frame_done_o single-cycle pulse after the last retire, busy_o=0.
  - start_i during busy_o=1 -> no effect.
  - rows=0 -> frame_done_o two cycles after start.
- Error and mid-frame reset:
  - tlast with tdest=3 while IP 3 has 0 outstanding -> err_o=1 and stays 1; counter stays 0.
  - rst asserted mid-ISSUE -> all outputs 0 next cycle, err_o cleared, no frame_done_o.
